debug_snapshot_sender: RTL



---
 rtl/debug_snapshot_sender_pkg.sv | 25 ++
 rtl/debug_snapshot_sender_if.sv | 24 ++
 rtl/debug_snapshot_sender_word_byte_serializer.sv | 43 ++++
 rtl/debug_snapshot_sender.sv | 113 +++++++++++
 4 files changed

// File: rtl/debug_snapshot_sender_pkg.sv
// Shared constants and state encoding for the snapshot dump sequencer.
package debug_snapshot_sender_pkg;

    localparam int unsigned CANT_BITS_CONTROL_DEF = 4;
    localparam int unsigned LONGITUD_DATO_DEF     = 32;
    localparam int unsigned WIDTH_BYTE_DEF        = 8;
    localparam int unsigned PRIMER_CODIGO_DEF     = 2;
    localparam int unsigned ULTIMO_CODIGO_DEF     = 11;
    localparam int unsigned BYTES_PER_WORD        = LONGITUD_DATO_DEF / WIDTH_BYTE_DEF;

    // Control codes 0 and 1 are fixed by the snapshot store; 12+ would clear it.
    localparam int unsigned CTRL_HOLD    = 0;
    localparam int unsigned CTRL_CAPTURE = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_SELECT  = 3'd2,
        ST_LATCH   = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5,
        ST_DONE    = 3'd6
    } state_e;

endpackage

// File: rtl/debug_snapshot_sender_if.sv
// Snapshot-store read-out and UART transmit handshake bundle.
interface debug_snapshot_sender_if
    import debug_snapshot_sender_pkg::*;
#(
    parameter int unsigned CANT_BITS_CONTROL = CANT_BITS_CONTROL_DEF,
    parameter int unsigned LONGITUD_DATO     = LONGITUD_DATO_DEF,
    parameter int unsigned WIDTH_BYTE        = WIDTH_BYTE_DEF
);
    logic [CANT_BITS_CONTROL-1:0] o_control;
    logic [LONGITUD_DATO-1:0]     i_dato;
    logic                         o_tx_start;
    logic [WIDTH_BYTE-1:0]        o_tx_data;
    logic                         i_tx_done;

    modport master (
        output o_control, o_tx_start, o_tx_data,
        input  i_dato, i_tx_done
    );

    modport slave (
        input  o_control, o_tx_start, o_tx_data,
        output i_dato, i_tx_done
    );
endinterface

// File: rtl/debug_snapshot_sender_word_byte_serializer.sv
// Holds one snapshot word and presents it MSB-first, one byte at a time.
module debug_snapshot_sender_word_byte_serializer
    import debug_snapshot_sender_pkg::*;
#(
    parameter int unsigned LONGITUD_DATO = LONGITUD_DATO_DEF,
    parameter int unsigned WIDTH_BYTE    = WIDTH_BYTE_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_word,
    input  logic                     shift_byte,
    input  logic [LONGITUD_DATO-1:0] word,
    output logic [WIDTH_BYTE-1:0]    byte_out,
    output logic                     last_byte
);
    localparam int unsigned BYTES = LONGITUD_DATO / WIDTH_BYTE;
    localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [LONGITUD_DATO-1:0] shift_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     last_q;

    // Load restarts the byte count; each shift exposes the next lower byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else if (load_word) begin
            shift_q <= word;
            cnt_q   <= '0;
            last_q  <= (BYTES == 1);
        end else if (shift_byte) begin
            shift_q <= shift_q << WIDTH_BYTE;
            cnt_q   <= cnt_q + 1'b1;
            last_q  <= (cnt_q == CNT_W'(BYTES - 2));
        end
    end

    assign byte_out  = shift_q[LONGITUD_DATO-1 -: WIDTH_BYTE];
    assign last_byte = last_q;

endmodule

// File: rtl/debug_snapshot_sender.sv
// Freezes a pipeline snapshot, walks read-out codes and streams each word to the UART.
module debug_snapshot_sender
    import debug_snapshot_sender_pkg::*;
#(
    parameter int unsigned CANT_BITS_CONTROL = CANT_BITS_CONTROL_DEF,
    parameter int unsigned LONGITUD_DATO     = LONGITUD_DATO_DEF,
    parameter int unsigned WIDTH_BYTE        = WIDTH_BYTE_DEF,
    parameter int unsigned PRIMER_CODIGO     = PRIMER_CODIGO_DEF,
    parameter int unsigned ULTIMO_CODIGO     = ULTIMO_CODIGO_DEF
) (
    input  logic                     i_clock,
    input  logic                     i_soft_reset,
    input  logic                     i_start,
    debug_snapshot_sender_if.master  bus,
    output logic                     o_busy,
    output logic                     o_done
);
    localparam int unsigned CB = CANT_BITS_CONTROL;

    state_e           state_q, state_d;
    logic [CB-1:0]    code_q, code_d;
    logic [CB-1:0]    control_q, control_d;
    logic             tx_start_q, busy_q, done_q;
    logic             load_c, shift_c, last_byte;
    logic [WIDTH_BYTE-1:0] byte_w;

    debug_snapshot_sender_word_byte_serializer #(
        .LONGITUD_DATO (LONGITUD_DATO),
        .WIDTH_BYTE    (WIDTH_BYTE)
    ) u_serializer (
        .clk        (i_clock),
        .rst_n      (i_soft_reset),
        .load_word  (load_c),
        .shift_byte (shift_c),
        .word       (bus.i_dato),
        .byte_out   (byte_w),
        .last_byte  (last_byte)
    );

    always_ff @(posedge i_clock or negedge i_soft_reset) begin
        if (!i_soft_reset) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
        end
    end

    // Next state, strobes, and the control code that goes with the next state.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        load_c    = 1'b0;
        shift_c   = 1'b0;
        control_d = CB'(CTRL_HOLD);
        case (state_q)
            ST_IDLE:    if (i_start) state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                code_d  = CB'(PRIMER_CODIGO);
                state_d = ST_SELECT;
            end
            ST_SELECT:  state_d = ST_LATCH;
            ST_LATCH: begin
                load_c  = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND:    state_d = ST_WAIT_TX;
            ST_WAIT_TX: begin
                if (bus.i_tx_done) begin
                    if (!last_byte) begin
                        shift_c = 1'b1;
                        state_d = ST_SEND;
                    end else if (code_q < CB'(ULTIMO_CODIGO)) begin
                        code_d  = code_q + 1'b1;
                        state_d = ST_SELECT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        case (state_d)
            ST_CAPTURE: control_d = CB'(CTRL_CAPTURE);
            ST_SELECT:  control_d = code_d;
            default:    control_d = CB'(CTRL_HOLD);
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge i_clock or negedge i_soft_reset) begin
        if (!i_soft_reset) begin
            control_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            control_q  <= control_d;
            tx_start_q <= (state_d == ST_SEND);
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_d == ST_DONE);
        end
    end

    assign bus.o_control  = control_q;
    assign bus.o_tx_start = tx_start_q;
    assign bus.o_tx_data  = byte_w;
    assign o_busy         = busy_q;
    assign o_done         = done_q;

endmodule
